// File: rtl/layer_output_serializer.sv
`default_nettype none
// ============================================================================
// layer_output_serializer: captures one all-valid frame of NN parallel neuron
// words and replays it as a ready/valid stream of (word, index, last).
// Revision: 1.0
// ============================================================================
module layer_output_serializer #(
  parameter  int NN        = 10,
  parameter  int dataWidth = 16,
  localparam int IDXW      = $clog2(NN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  output logic [IDXW-1:0]         out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_overflow,
  output logic                    err_partial
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

  state_t                         state_q, state_d;
  logic [IDXW-1:0]                index_q, index_d;
  logic [NN-1:0][dataWidth-1:0]   buffer_q, buffer_d;
  logic                           err_overflow_q, err_overflow_d;
  logic                           err_partial_q, err_partial_d;

  logic all_valid;
  logic partial_valid;
  logic xfer;
  logic final_xfer;

  always_comb begin
    all_valid     = &in_valid;
    partial_valid = (|in_valid) && !all_valid;
    xfer          = (state_q == SEND) && out_ready;
    final_xfer    = xfer && (index_q == LAST_IDX);

    state_d        = state_q;
    index_d        = index_q;
    buffer_d       = buffer_q;
    err_overflow_d = err_overflow_q;
    err_partial_d  = err_partial_q;

    if (partial_valid) begin
      err_partial_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (all_valid) begin
          buffer_d = in_data;
          index_d  = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (final_xfer) begin
          index_d = '0;
          // A frame arriving with the last transfer chains on with no bubble.
          if (all_valid) begin
            buffer_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          index_d = index_q + 1'b1;
        end
        if (all_valid && !final_xfer) begin
          err_overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      index_q        <= '0;
      buffer_q       <= '0;
      err_overflow_q <= 1'b0;
      err_partial_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      buffer_q       <= buffer_d;
      err_overflow_q <= err_overflow_d;
      err_partial_q  <= err_partial_d;
    end
  end

  // Outputs read zero whenever no word is being presented.
  assign out_valid    = (state_q == SEND);
  assign out_data     = out_valid ? buffer_q[index_q] : '0;
  assign out_index    = out_valid ? index_q : '0;
  assign out_last     = out_valid && (index_q == LAST_IDX);
  assign busy         = (state_q == SEND);
  assign err_overflow = err_overflow_q;
  assign err_partial  = err_partial_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// tb_layer_output_serializer: directed vector bench for layer_output_serializer.
// Revision: 1.0
// ============================================================================
module tb_layer_output_serializer;

  localparam int NN   = 10;
  localparam int DW   = 16;
  localparam int IDXW = $clog2(NN);
  localparam logic [NN-1:0] ALL = {NN{1'b1}};

  logic               clk = 1'b0;
  logic               rst;
  logic [NN-1:0]      in_valid;
  logic [NN*DW-1:0]   in_data;
  logic               out_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [IDXW-1:0]    out_index;
  logic               out_last;
  logic               busy;
  logic               err_overflow;
  logic               err_partial;

  int n_vec = 0;
  int n_err = 0;
  logic g_ovf = 1'b0;
  logic g_part = 1'b0;

  layer_output_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_partial  (err_partial)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            r;
    logic [NN-1:0]   iv;
    logic [DW-1:0]   base;
    logic            rdy;
    logic            ev;
    logic [DW-1:0]   ed;
    logic [IDXW-1:0] ei;
    logic            el;
    logic            eb;
    logic            eo;
    logic            ep;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [NN*DW-1:0] frame(input logic [DW-1:0] base);
    logic [NN*DW-1:0] f;
    for (int i = 0; i < NN; i++) f[i*DW +: DW] = base + DW'(i);
    return f;
  endfunction

  function automatic vec_t mk(input logic r, input logic [NN-1:0] iv, input logic [DW-1:0] base,
                              input logic rdy, input logic ev, input logic [DW-1:0] ed,
                              input int ei, input logic eb, input logic eo, input logic ep);
    vec_t v;
    v.r = r; v.iv = iv; v.base = base; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ei = IDXW'(ei); v.el = ev && (ei == NN - 1);
    v.eb = eb; v.eo = eo; v.ep = ep;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
  task automatic step(input vec_t v, input string name);
    logic [DW+IDXW+4:0] got, exp;
    @(negedge clk);
    rst = v.r; in_valid = v.iv; in_data = frame(v.base); out_ready = v.rdy;
    @(posedge clk);
    #1;
    got = {out_valid, out_data, out_index, out_last, busy, err_overflow, err_partial};
    exp = {v.ev, v.ed, v.ei, v.el, v.eb, v.eo, v.ep};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: v/data/idx/last/busy/ovf/part got %b/%h/%0d/%b/%b/%b/%b want %b/%h/%0d/%b/%b/%b/%b",
               name, n_vec, out_valid, out_data, out_index, out_last, busy, err_overflow, err_partial,
               v.ev, v.ed, v.ei, v.el, v.eb, v.eo, v.ep);
    end
  endtask

  task automatic exp_word(input logic r, input logic [NN-1:0] iv, input logic [DW-1:0] base,
                          input logic rdy, input logic [DW-1:0] wbase, input int idx, input string name);
    step(mk(r, iv, base, rdy, 1'b1, wbase + DW'(idx), idx, 1'b1, g_ovf, g_part), name);
  endtask

  task automatic exp_idle(input logic r, input logic [NN-1:0] iv, input logic [DW-1:0] base,
                          input logic rdy, input string name);
    step(mk(r, iv, base, rdy, 1'b0, '0, 0, 1'b0, g_ovf, g_part), name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, nidx;
    logic rdy;
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Reset with an all-valid frame present, basic stream, then partial-valid frames.
    tbl.push_back(mk(1, ALL, 16'h0100, 1, 0, 16'h0, 0, 0, 0, 0));
    tbl.push_back(mk(1, ALL, 16'h0100, 1, 0, 16'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0,  16'h0,    1, 0, 16'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, ALL, 16'h0100, 1, 1, 16'h0100, 0, 1, 0, 0));
    for (int k = 1; k < NN; k++)
      tbl.push_back(mk(0, '0, 16'h0, 1, 1, 16'h0100 + DW'(k), k, 1, 0, 0));
    tbl.push_back(mk(0, '0,       16'h0,    1, 0, 16'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 10'h001,  16'h0500, 1, 0, 16'h0, 0, 0, 0, 1));
    tbl.push_back(mk(0, '0,       16'h0,    1, 0, 16'h0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 10'h3FE,  16'h0500, 1, 0, 16'h0, 0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], "table");
    g_part = 1'b1;

    // Full frame after partial still streams.
    exp_word(0, ALL, 16'h0300, 1, 16'h0300, 0, "after_partial_cap");
    for (int k = 1; k < NN; k++) exp_word(0, '0, 16'h0, 1, 16'h0300, k, "after_partial");
    exp_idle(0, '0, 16'h0, 1, "after_partial_end");

    // Backpressure: ready pattern 1,0,0 repeating; held words must not move.
    exp_word(0, ALL, 16'h0100, 0, 16'h0100, 0, "bp_cap");
    idx = 0;
    for (int c = 0; c < 60 && idx < NN; c++) begin
      rdy  = (c % 3 == 0);
      nidx = rdy ? idx + 1 : idx;
      if (nidx == NN) exp_idle(0, '0, 16'h0, rdy, "bp_end");
      else            exp_word(0, '0, 16'h0, rdy, 16'h0100, nidx, "bp");
      idx = nidx;
    end
    if (idx != NN) begin
      n_vec++; n_err++;
      $display("FAIL bp_count: transfers %0d want %0d", idx, NN);
    end

    // Back-to-back frames, then an overflow frame mid-stream.
    exp_word(0, ALL, 16'h0100, 1, 16'h0100, 0, "b2b_cap");
    for (int k = 1; k < NN; k++) exp_word(0, '0, 16'h0, 1, 16'h0100, k, "b2b_f1");
    exp_word(0, ALL, 16'h0200, 1, 16'h0200, 0, "b2b_nogap");
    for (int k = 1; k <= 4; k++) exp_word(0, '0, 16'h0, 1, 16'h0200, k, "b2b_f2");
    g_ovf = 1'b1;
    exp_word(0, ALL, 16'h0300, 1, 16'h0200, 5, "b2b_ovf");
    for (int k = 6; k < NN; k++) exp_word(0, '0, 16'h0, 1, 16'h0200, k, "b2b_f2_tail");
    exp_idle(0, '0, 16'h0, 1, "b2b_end");

    // Reset mid-stream at index 5, then a fresh frame from index 0.
    exp_word(0, ALL, 16'h0100, 1, 16'h0100, 0, "rm_cap");
    for (int k = 1; k <= 5; k++) exp_word(0, '0, 16'h0, 1, 16'h0100, k, "rm_pre");
    g_ovf = 1'b0; g_part = 1'b0;
    exp_idle(1, '0, 16'h0, 1, "rm_rst");
    exp_idle(0, '0, 16'h0, 1, "rm_after");
    exp_word(0, ALL, 16'h0400, 1, 16'h0400, 0, "rm_new_cap");
    for (int k = 1; k < NN; k++) exp_word(0, '0, 16'h0, 1, 16'h0400, k, "rm_new");
    exp_idle(0, '0, 16'h0, 1, "rm_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
